// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port synchronous framebuffer SRAM between display
// scanout and a pixel writer. Scanout prefetches pixels into a show-ahead
// FIFO that the display drains with pix_req. The writer uses a valid/ready
// handshake. Every RAM slot is decided here, one operation per cycle.
//
// Optional feature macro: ARB_UNDERFLOW_CNT_EN
//   Adds a saturating 16-bit underflow_cnt output that counts cycles with
//   pix_req while the FIFO is empty. It clears on reset and on frame_start.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   frame_start         restart scanout for a new frame (vertical blanking)
//   pix_req, pix_data   display pop request and FIFO head (show-ahead)
//   wr_valid, wr_ready  writer handshake (wr_ready is combinational)
//   wr_addr, wr_data    writer address and data
//   mem_en/we/addr/wdata registered RAM command
//   mem_rdata           RAM read data, one cycle after a read command
//   fetch_done          every pixel of the current frame has been issued
//   underflow           sticky: pix_req arrived with an empty FIFO
//   underflow_cnt       (ARB_UNDERFLOW_CNT_EN only) empty-pop cycle count
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int AW         = 19,
    parameter int DW         = 8,
    parameter int HSIZE      = 800,
    parameter int VSIZE      = 600,
    parameter int FIFO_DEPTH = 16,
    parameter int LOW_WM     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_start,
    input  logic          pix_req,
    output logic [DW-1:0] pix_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          fetch_done,
`ifdef ARB_UNDERFLOW_CNT_EN
    output logic [15:0]   underflow_cnt,
`endif
    output logic          underflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(HSIZE * VSIZE - 1);

    logic [DW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] fetch_ptr;

    // Read tags follow each granted read through the RAM: tag1 while the
    // command is on the bus, tag2 while its data is on mem_rdata.
    logic tag1;
    logic tag2;

    logic [CW:0] level;
    logic        read_ok;
    logic        urgent;
    logic        do_read;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    // Occupancy counts reads already in flight, so the FIFO can never overflow.
    assign level      = {1'b0, fifo_count} + {{CW{1'b0}}, tag1} + {{CW{1'b0}}, tag2};
    assign read_ok    = !fetch_done && (level < (CW+1)'(FIFO_DEPTH));
    assign urgent     = read_ok && (fifo_count < CW'(LOW_WM));
    assign wr_ready   = wr_valid && !urgent;
    // A write wins any non-urgent slot; the read grant is dropped on frame_start.
    assign do_read    = read_ok && !wr_ready && !frame_start;

    assign fifo_empty = (fifo_count == '0);
    assign push       = tag2 && !frame_start;
    assign pop        = pix_req && !fifo_empty && !frame_start;
    assign pix_data   = fifo_empty ? '0 : fifo_mem[rd_ptr];

    // NOTE: the FIFO storage has no reset; the count and pointers alone define
    // which entries are valid, so clearing the array would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            fetch_ptr  <= '0;
            fetch_done <= 1'b0;
            tag1       <= 1'b0;
            tag2       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            underflow  <= 1'b0;
        end else begin
            // RAM command for the slot decided this cycle.
            if (wr_ready) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else if (do_read) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= fetch_ptr;
            end else begin
                mem_en    <= 1'b0;
                mem_we    <= 1'b0;
            end

            if (frame_start) begin
                // Flush and discard in-flight reads by clearing their tags.
                fetch_ptr  <= '0;
                fetch_done <= 1'b0;
                tag1       <= 1'b0;
                tag2       <= 1'b0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
            end else begin
                if (do_read) begin
                    fetch_ptr <= fetch_ptr + 1'b1;
                    if (fetch_ptr == LAST_ADDR) begin
                        fetch_done <= 1'b1;
                    end
                end
                tag1 <= do_read;
                tag2 <= tag1;
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + 1'b1;
                    2'b01:   fifo_count <= fifo_count - 1'b1;
                    default: fifo_count <= fifo_count;
                endcase
                if (pix_req && fifo_empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

`ifdef ARB_UNDERFLOW_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || frame_start) begin
            underflow_cnt <= '0;
        end else if (pix_req && fifo_empty && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
Shares one single-port synchronous framebuffer SRAM between two users. The first is display scanout, which prefetches pixels into a small show-ahead FIFO consumed in step with the timing generator's data_enable. The second is a writer, the CNN result/pixel writer, using a valid/ready handshake. The block sits between the VGA timing generator, the framebuffer RAM and the writer, and schedules every RAM slot.

Parameters:
AW, 19, framebuffer address width
DW, 8, pixel width
HSIZE, 800, visible pixels per line
VSIZE, 600, visible lines per frame
FIFO_DEPTH, 16, scanout FIFO entries (power of 2, >= 4)
LOW_WM, 4, FIFO level below which scanout reads take priority over writes

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
frame_start  in  1  one-cycle pulse during vertical blanking; restarts scanout for a new frame
pix_req  in  1  display consumes one pixel this cycle (driven from data_enable)
pix_data  out  DW  FIFO head pixel, valid in the same cycle as pix_req
wr_valid  in  1  writer request
wr_ready  out  1  write granted this cycle (combinational)
wr_addr  in  AW  write address
wr_data  in  DW  write data
mem_en  out  1  RAM enable (registered)
mem_we  out  1  RAM write enable (registered)
mem_addr  out  AW  RAM address (registered)
mem_wdata  out  DW  RAM write data (registered)
mem_rdata  in  DW  RAM read data, valid one cycle after mem_en && !mem_we
fetch_done  out  1  all HSIZE*VSIZE pixels of the current frame have been issued
underflow  out  1  sticky: pix_req arrived while the FIFO was empty

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - mem_en, mem_we, mem_addr, mem_wdata, wr_ready, fetch_done and underflow all 0.
  - FIFO empty, fetch pointer 0, in-flight count 0.
  - pix_data reads 0 while the FIFO is empty.
- Slot grant: at most one RAM operation is decided per cycle (cycle N). It is driven on mem_* in N+1. Read data returns in N+2 and is written into the FIFO at the end of N+2. Read latency from decision to FIFO is therefore 2 cycles; in-flight reads are 0..2.
- Read eligibility: read_ok = !fetch_done && (fifo_count + inflight) < FIFO_DEPTH. This guarantees the FIFO never overflows.
- Priority (decided each cycle):
  1. read_ok && fifo_count < LOW_WM: read (urgent).
  2. else wr_valid: write; wr_ready=1; the transfer occurs on wr_valid && wr_ready.
  3. else read_ok: read.
  4. else idle (mem_en=0 next cycle).
- Reads: mem_addr = fetch pointer, which increments per read issued. When the pointer reaches HSIZE*VSIZE-1 and that read is issued, fetch_done is set next cycle.
- Writes: mem_addr = wr_addr, mem_wdata = wr_data, mem_we=1. A write never alters the fetch pointer.
- Pop: pix_req with a non-empty FIFO pops the head. pix_data is combinational from the FIFO head (show-ahead).
- Empty FIFO with pix_req: no pop, pix_data=0, underflow set; underflow is cleared only by reset.
- Simultaneous push and pop: both take effect; count is unchanged.
- frame_start, applied next cycle:
  - FIFO flushed, fetch pointer = 0, fetch_done = 0.
  - In-flight reads are discarded: their returning data is not pushed.
  - A pix_req in the same cycle is ignored (no pop, no underflow).
  - A write granted in the same cycle completes normally. The read grant in that cycle is suppressed.
- frame_start is a decision-cycle input. With one pulse per frame placed in vertical blanking, the FIFO fills before the first visible pixel.
- Writer starvation: a write waits only while the FIFO is below LOW_WM. Once the FIFO is full or fetch_done is set, every cycle is available to the writer.

Optional Feature:
ARB_UNDERFLOW_CNT_EN
- Defined: adds output underflow_cnt [15:0].
  - Counts cycles with pix_req && FIFO empty (excluding frame_start cycles).
  - Saturates at 16'hFFFF; cleared to 0 on reset and on frame_start.
- Undefined: the port and counter are absent; only the sticky underflow flag exists.

Test Plan:
1. Reset then idle, with HSIZE=4, VSIZE=2, FIFO_DEPTH=16 and no pix_req:
   - reads issue at addresses 0..7 on consecutive cycles;
   - fetch_done=1 after the 8th read;
   - FIFO count reaches 8; mem_en=0 afterwards.
2. After frame_start, FIFO full (16 entries of a ramp image), wr_valid held with wr_addr=0x100 and wr_data=0xAA:
   - wr_ready=1 the same cycle; mem_we=1 with addr 0x100 the next cycle;
   - sustained pix_req draining below LOW_WM=4 drops wr_ready to 0 until the count reaches 4 again.
3. pix_req asserted 5 cycles after frame_start, with FIFO empty:
   - pix_data=0 and underflow=1, remaining 1 after frame_start;
   - with ARB_UNDERFLOW_CNT_EN, underflow_cnt increments per empty cycle and clears on frame_start.
4. frame_start pulsed while 2 reads are in flight:
   - FIFO empty for the next 2 cycles; the returning data is dropped;
   - the next read addresses 0.
5. Continuous pix_req (1 pixel/cycle) with wr_valid held high after a full-FIFO prefill:
   - no underflow over 8 pixels;
   - wr_ready is granted only in cycles where fifo_count >= 4 or no read is eligible.
6. rst_n=0 mid-frame with fetch pointer 37 and FIFO count 9:
   - next cycle all outputs are 0, the FIFO is empty, and the first read after reset targets address 0.
